// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution kernel engine.
//   conv_state_e : engine FSM states
//   conv_mode_e  : coefficient interpretation (unsigned blur / signed gradient)
//   acc_width()  : accumulator width needed for a SIZE x SIZE dot product
//   clamp_range(): clamp a wide signed value into [0, hi]
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        NORM,
        HOLD
    } conv_state_e;

    typedef enum logic {
        CONV_UNSIGNED = 1'b0,
        CONV_SIGNED   = 1'b1
    } conv_mode_e;

    // Width used for the normalisation/clamp arithmetic; wide enough that the
    // rounding add and any shift amount can never overflow.
    localparam int CLAMP_W = 64;

    // Sign bit plus room for SIZE*SIZE full-scale products.
    function automatic int acc_width(input int size, input int pix_w, input int coef_w);
        return pix_w + coef_w + $clog2(size * size) + 1;
    endfunction

    function automatic logic signed [CLAMP_W-1:0] clamp_range(
        input logic signed [CLAMP_W-1:0] v,
        input logic signed [CLAMP_W-1:0] hi
    );
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/conv_lane_mac.sv
// LANES parallel multipliers followed by a reduction adder.
// Ports:
//   pix     : LANES unsigned pixels, lane l at [l*PIX_W +: PIX_W]
//   coef    : LANES coefficients, lane l at [l*COEF_W +: COEF_W]
//   mode    : 0 = coefficients unsigned, 1 = two's complement
//   lane_en : per-lane enable; disabled lanes contribute zero
//   psum    : combinational signed sum of the enabled products
module conv_lane_mac
    import conv_pkg::*;
#(
    parameter int LANES  = 5,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 21
) (
    input  logic [LANES*PIX_W-1:0]  pix,
    input  logic [LANES*COEF_W-1:0] coef,
    input  logic                    mode,
    input  logic [LANES-1:0]        lane_en,
    output logic signed [ACC_W-1:0] psum
);

    logic signed [PIX_W:0]     px_x [LANES];
    logic signed [COEF_W:0]    cf_x [LANES];
    logic signed [ACC_W-1:0]   prod [LANES];

    // One extra bit on each operand lets a single signed multiplier serve
    // both modes: pixels always zero-extend, coefficients follow the mode.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            px_x[l] = {1'b0, pix[l*PIX_W +: PIX_W]};
            if (conv_mode_e'(mode) == CONV_SIGNED)
                cf_x[l] = {coef[l*COEF_W + COEF_W - 1], coef[l*COEF_W +: COEF_W]};
            else
                cf_x[l] = {1'b0, coef[l*COEF_W +: COEF_W]};
            prod[l] = lane_en[l] ? ACC_W'(px_x[l]) * ACC_W'(cf_x[l]) : '0;
        end
    end

    always_comb begin
        psum = '0;
        for (int l = 0; l < LANES; l++)
            psum = psum + prod[l];
    end

endmodule

// File: rtl/conv_kernel_engine.sv
// SIZE x SIZE window-times-kernel convolution engine.
// Captures one window/kernel job, accumulates LANES products per cycle over
// NG = ceil(SIZE*SIZE/LANES) cycles, then shifts, rounds and clamps the sum to
// an unsigned PIX_W pixel.
// Build option: define CONV_ROUND_EN for round-half-up before the shift;
// otherwise the shift truncates toward minus infinity.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : job handshake (in_ready only while idle)
//   window_i          : pixels, element k = r*SIZE+c at [k*PIX_W +: PIX_W]
//   kernel_i          : coefficients at the same element index
//   signed_mode_i     : 0 unsigned coefficients, 1 two's complement
//   norm_shift_i      : arithmetic right shift applied to the sum
//   out_valid/out_ready : result handshake
//   pixel_o, sat_o    : clamped result and clamp indicator
module conv_kernel_engine
    import conv_pkg::*;
#(
    parameter  int SIZE   = 5,
    parameter  int PIX_W  = 8,
    parameter  int COEF_W = 8,
    parameter  int LANES  = 5,
    localparam int ACC_W  = acc_width(SIZE, PIX_W, COEF_W),
    localparam int SH_W   = $clog2(ACC_W)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SIZE*SIZE*PIX_W-1:0]  window_i,
    input  logic [SIZE*SIZE*COEF_W-1:0] kernel_i,
    input  logic                      signed_mode_i,
    input  logic [SH_W-1:0]           norm_shift_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIX_W-1:0]          pixel_o,
    output logic                      sat_o
);

    localparam int NE    = SIZE * SIZE;
    localparam int NG    = (NE + LANES - 1) / LANES;
    localparam int NP    = NG * LANES;
    localparam int GRP_W = (NG > 1) ? $clog2(NG) : 1;
    localparam logic signed [CLAMP_W-1:0] PIX_MAX = (64'sd1 <<< PIX_W) - 64'sd1;

    conv_state_e             state_q, state_d;
    logic [NP*PIX_W-1:0]     win_q;
    logic [NP*COEF_W-1:0]    ker_q;
    conv_mode_e              mode_q;
    logic [SH_W-1:0]         shift_q;
    logic [GRP_W-1:0]        grp_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] psum;
    logic [LANES-1:0]        lane_en;
    logic                    accept;
    logic                    last_grp;

    logic signed [CLAMP_W-1:0] acc_wide;
    logic signed [CLAMP_W-1:0] round_v;
    logic signed [CLAMP_W-1:0] norm_v;
    logic signed [CLAMP_W-1:0] clamped_v;

    // in_ready is masked by rst so nothing is accepted in the reset cycle.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_grp  = (grp_q == GRP_W'(NG - 1));
    assign out_valid = (state_q == HOLD);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = ACCUM;
            ACCUM:   if (last_grp)  state_d = NORM;
            NORM:                   state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Job capture. The operand registers are padded to NG*LANES elements and
    // shift down by one lane group per ACCUM cycle, so the MAC always reads
    // the low LANES elements; padding elements are zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q   <= (NP*PIX_W)'(window_i);
            ker_q   <= (NP*COEF_W)'(kernel_i);
            mode_q  <= conv_mode_e'(signed_mode_i);
            shift_q <= norm_shift_i;
        end else if (state_q == ACCUM) begin
            win_q <= win_q >> (LANES*PIX_W);
            ker_q <= ker_q >> (LANES*COEF_W);
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++)
            lane_en[l] = (int'(grp_q) * LANES + l) < NE;
    end

    conv_lane_mac #(
        .LANES  (LANES),
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .pix     (win_q[LANES*PIX_W-1:0]),
        .coef    (ker_q[LANES*COEF_W-1:0]),
        .mode    (mode_q),
        .lane_en (lane_en),
        .psum    (psum)
    );

    // Normalisation is evaluated in a wide signed domain so the rounding
    // offset and large shift amounts cannot wrap.
    always_comb begin
        acc_wide = CLAMP_W'(acc_q);
`ifdef CONV_ROUND_EN
        round_v = (shift_q != '0) ? (64'sd1 <<< (shift_q - SH_W'(1))) : 64'sd0;
`else
        round_v = 64'sd0;
`endif
        norm_v    = (acc_wide + round_v) >>> shift_q;
        clamped_v = clamp_range(norm_v, PIX_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_q   <= '0;
            acc_q   <= '0;
            pixel_o <= '0;
            sat_o   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        grp_q <= '0;
                        acc_q <= '0;
                    end
                end
                ACCUM: begin
                    acc_q <= acc_q + psum;
                    grp_q <= grp_q + GRP_W'(1);
                end
                NORM: begin
                    pixel_o <= clamped_v[PIX_W-1:0];
                    sat_o   <= (clamped_v != norm_v);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_kernel_engine.sv
module tb_conv_kernel_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic in_valid, out_ready, sel, mode;
    logic [4:0] shift;
    logic in_valid3, in_valid25;
    logic [9*8-1:0]  win3, ker3;
    logic [25*8-1:0] win25, ker25;
    logic in_ready3, out_valid3, sat3;
    logic in_ready25, out_valid25, sat25;
    logic [7:0] pixel3, pixel25;
    logic ir, ov, st;
    logic [7:0] px;

    int win_a[25];
    int ker_a[25];
    int n_vec = 0;
    int n_err = 0;

    assign in_valid3  = in_valid & ~sel;
    assign in_valid25 = in_valid & sel;

    always_comb begin
        ir = sel ? in_ready25  : in_ready3;
        ov = sel ? out_valid25 : out_valid3;
        px = sel ? pixel25     : pixel3;
        st = sel ? sat25       : sat3;
    end

    conv_kernel_engine #(.SIZE(3), .PIX_W(8), .COEF_W(8), .LANES(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .window_i(win3), .kernel_i(ker3), .signed_mode_i(mode), .norm_shift_i(shift),
        .out_valid(out_valid3), .out_ready(out_ready), .pixel_o(pixel3), .sat_o(sat3)
    );

    conv_kernel_engine #(.SIZE(5), .PIX_W(8), .COEF_W(8), .LANES(25)) u_dut25 (
        .clk(clk), .rst(rst), .in_valid(in_valid25), .in_ready(in_ready25),
        .window_i(win25), .kernel_i(ker25), .signed_mode_i(mode), .norm_shift_i(shift),
        .out_valid(out_valid25), .out_ready(out_ready), .pixel_o(pixel25), .sat_o(sat25)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain dot product, optional round-half-up, arithmetic shift, clamp.
    function automatic void ref_model(input int n, input bit md, input int sh,
                                      output int epx, output bit est);
        longint acc;
        longint r;
        int c;
        acc = 0;
        for (int k = 0; k < n; k++) begin
            c = ker_a[k];
            if (md && c >= 128) c = c - 256;
            acc += longint'(win_a[k]) * longint'(c);
        end
        r = acc;
`ifdef CONV_ROUND_EN
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
        r = r >>> sh;
        if (r < 0) begin
            epx = 0; est = 1'b1;
        end else if (r > 255) begin
            epx = 255; est = 1'b1;
        end else begin
            epx = int'(r); est = 1'b0;
        end
    endfunction

    task automatic load(input bit s);
        if (s) begin
            for (int k = 0; k < 25; k++) begin
                win25[k*8 +: 8] = 8'(win_a[k]);
                ker25[k*8 +: 8] = 8'(ker_a[k]);
            end
        end else begin
            for (int k = 0; k < 9; k++) begin
                win3[k*8 +: 8] = 8'(win_a[k]);
                ker3[k*8 +: 8] = 8'(ker_a[k]);
            end
        end
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < 9; k++) begin
            win3[k*8 +: 8] = 8'($urandom);
            ker3[k*8 +: 8] = 8'($urandom);
        end
        for (int k = 0; k < 25; k++) begin
            win25[k*8 +: 8] = 8'($urandom);
            ker25[k*8 +: 8] = 8'($urandom);
        end
        mode  = 1'($urandom);
        shift = 5'($urandom);
    endtask

    task automatic randomize_arrays();
        for (int k = 0; k < 25; k++) begin
            win_a[k] = int'($urandom_range(0, 255));
            ker_a[k] = int'($urandom_range(0, 255));
        end
    endtask

    task automatic run_job(input bit s, input bit md, input int sh, input int hold, input string tag);
        int n, ng, epx, lat;
        bit est, seen;
        logic [7:0] p0;
        logic s0;
        n  = s ? 25 : 9;
        ng = s ? 1 : 5;
        ref_model(n, md, sh, epx, est);
        @(negedge clk);
        sel = s;
        load(s);
        mode = md;
        shift = 5'(sh);
        in_valid = 1'b1;
        #1;
        chk({tag, "/in_ready_idle"}, ir, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (ov) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({tag, "/latency"}, lat, ng + 1);
        chk({tag, "/in_ready_busy"}, ir, 0);
        chk({tag, "/pixel"}, px, epx);
        chk({tag, "/sat"}, st, est);
        p0 = px;
        s0 = st;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "/hold_valid"}, ov, 1);
            chk({tag, "/hold_pixel"}, px, p0);
            chk({tag, "/hold_sat"}, st, s0);
            chk({tag, "/hold_in_ready"}, ir, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/valid_drop"}, ov, 0);
        chk({tag, "/in_ready_back"}, ir, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit ov_seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        mode = 1'b0; shift = '0;
        win3 = '0; ker3 = '0; win25 = '0; ker25 = '0;
        for (int k = 0; k < 25; k++) begin win_a[k] = 0; ker_a[k] = 0; end

        // Reset state
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst/in_ready3_during", in_ready3, 0);
        chk("rst/in_ready25_during", in_ready25, 0);
        rst = 1'b0;
        #1;
        chk("rst/in_ready3_after", in_ready3, 1);
        chk("rst/in_ready25_after", in_ready25, 1);
        chk("rst/out_valid", out_valid3, 0);
        chk("rst/pixel", pixel3, 0);
        chk("rst/sat", sat3, 0);

        // Gaussian, flat 100
        ker_a[0:8] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        for (int k = 0; k < 9; k++) win_a[k] = 100;
        run_job(1'b0, 1'b0, 4, 0, "gauss_flat");

        // Gaussian, bright centre: sum 920
        for (int k = 0; k < 9; k++) win_a[k] = 10;
        win_a[4] = 200;
        run_job(1'b0, 1'b0, 4, 0, "gauss_centre");

        // Sobel-x, rising edge -> +1020
        ker_a[0:8] = '{255, 0, 1, 254, 0, 2, 255, 0, 1};
        win_a[0:8] = '{0, 128, 255, 0, 128, 255, 0, 128, 255};
        run_job(1'b0, 1'b1, 0, 0, "sobel_pos");

        // Mirror -> -1020
        win_a[0:8] = '{255, 128, 0, 255, 128, 0, 255, 128, 0};
        run_job(1'b0, 1'b1, 0, 0, "sobel_neg");
        run_job(1'b0, 1'b0, 0, 0, "sobel_unsigned");

        // Backpressure for 10 cycles, then a fresh job
        randomize_arrays();
        run_job(1'b0, 1'($urandom), int'($urandom_range(0, 20)), 10, "backpressure");
        randomize_arrays();
        run_job(1'b0, 1'($urandom), int'($urandom_range(0, 20)), 0, "after_bp");

        // Reset in the middle of ACCUM
        randomize_arrays();
        @(negedge clk);
        sel = 1'b0;
        load(1'b0);
        in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort/in_ready_rst", in_ready3, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort/out_valid", out_valid3, 0);
        chk("abort/pixel", pixel3, 0);
        chk("abort/sat", sat3, 0);
        chk("abort/in_ready", in_ready3, 1);
        ov_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid3) ov_seen = 1'b1;
        end
        chk("abort/no_result", ov_seen, 0);
        randomize_arrays();
        run_job(1'b0, 1'($urandom), int'($urandom_range(0, 20)), 0, "after_abort");

        // Fully parallel instance: one group, result after edge T+2
        for (int k = 0; k < 25; k++) begin win_a[k] = 100; ker_a[k] = 1; end
        run_job(1'b1, 1'b0, 0, 0, "l25_flat");

        // Randomized jobs on both instances
        for (int i = 0; i < 24; i++) begin
            bit s;
            s = (i % 3 == 2);
            randomize_arrays();
            run_job(s, 1'($urandom), int'($urandom_range(0, s ? 21 : 20)),
                    int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
